// File: rtl/vga_pattern_sequencer_pkg.sv
// Shared definitions for the pattern sequencer and the pattern generator:
// pattern codes, default code width and the sequencer FSM encoding.
package vga_pattern_sequencer_pkg;

  localparam int DEF_PATTERN_WIDTH = 3;

  localparam logic [DEF_PATTERN_WIDTH-1:0] PAT_SOLID   = 3'd0;
  localparam logic [DEF_PATTERN_WIDTH-1:0] PAT_BARS    = 3'd1;
  localparam logic [DEF_PATTERN_WIDTH-1:0] PAT_CHECKER = 3'd2;
  localparam logic [DEF_PATTERN_WIDTH-1:0] PAT_BORDER  = 3'd3;

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_AUTO   = 1'b1
  } state_t;

endpackage

// File: rtl/vga_pattern_sequencer_sync_debounce.sv
// Two-flop synchroniser followed by a stability debouncer for one raw switch.
// The stable output only flips after the synchronised value disagrees with it
// for DEBOUNCE_CYCLES consecutive cycles.
module sync_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_stable
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LP_CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_meta;
  logic          r_sync;
  logic          r_stable;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
      // Any return to the stable value restarts the qualification window.
      if (r_sync == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == LP_CNT_LAST) begin
        r_stable <= r_sync;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/vga_pattern_sequencer.sv
// Frame-synchronous test-pattern selector: debounced manual select or auto
// cycling, with every pattern change committed only on a vsync rising edge.
module vga_pattern_sequencer
  import vga_pattern_sequencer_pkg::*;
#(
  parameter int NUM_PATTERNS       = 4,
  parameter int PATTERN_WIDTH      = DEF_PATTERN_WIDTH,
  parameter int DEBOUNCE_CYCLES    = 250000,
  parameter int FRAMES_PER_PATTERN = 60
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_sel0,
  input  logic                     i_sel1,
  input  logic                     i_auto,
  input  logic                     i_vsync,
  output logic [PATTERN_WIDTH-1:0] o_pattern,
  output logic                     o_frame_start,
  output logic                     o_auto_active
);

  localparam int FCW = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
  localparam int PW1 = PATTERN_WIDTH + 1;
  localparam logic [FCW-1:0]           LP_FCNT_LAST = FCW'(FRAMES_PER_PATTERN - 1);
  localparam logic [PW1-1:0]           LP_NUM       = PW1'(NUM_PATTERNS);
  localparam logic [PATTERN_WIDTH-1:0] LP_PAT_MAX   = PATTERN_WIDTH'(NUM_PATTERNS - 1);

  logic w_sel0;
  logic w_sel1;
  logic w_auto;

  sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sel0 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_raw(i_sel0), .o_stable(w_sel0)
  );
  sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sel1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_raw(i_sel1), .o_stable(w_sel1)
  );
  sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_auto (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_raw(i_auto), .o_stable(w_auto)
  );

  state_t                   r_state;
  logic                     r_vs_d;
  logic                     r_auto_d;
  logic [FCW-1:0]           r_frame_cnt;
  logic [PATTERN_WIDTH-1:0] r_pattern;
  logic                     r_frame_start;
  logic                     r_auto_active;

  logic                     w_frame_start;
  logic                     w_auto_rise;
  logic                     w_auto_fall;
  logic [PW1-1:0]           w_tgt_ext;
  logic [PATTERN_WIDTH-1:0] w_target;
  logic [PW1-1:0]           w_inc;
  logic [PATTERN_WIDTH-1:0] w_next_pat;

  assign w_frame_start = i_vsync & ~r_vs_d;
  assign w_auto_rise   = w_auto & ~r_auto_d;
  assign w_auto_fall   = ~w_auto & r_auto_d;

  // Out-of-range manual codes saturate to the last legal pattern.
  assign w_tgt_ext  = PW1'({w_sel0, w_sel1});
  assign w_target   = (w_tgt_ext >= LP_NUM) ? LP_PAT_MAX : w_tgt_ext[PATTERN_WIDTH-1:0];
  assign w_inc      = {1'b0, r_pattern} + 1'b1;
  assign w_next_pat = (w_inc >= LP_NUM) ? '0 : w_inc[PATTERN_WIDTH-1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_MANUAL;
      r_vs_d        <= 1'b1;
      r_auto_d      <= 1'b0;
      r_frame_cnt   <= '0;
      r_pattern     <= '0;
      r_frame_start <= 1'b0;
      r_auto_active <= 1'b0;
    end else begin
      r_vs_d        <= i_vsync;
      r_auto_d      <= w_auto;
      r_frame_start <= w_frame_start;

      // Frame-start action uses the state as it was before any mode change.
      if (w_frame_start) begin
        if (r_state == ST_MANUAL) begin
          r_pattern <= w_target;
        end else if (r_frame_cnt == LP_FCNT_LAST) begin
          r_pattern   <= w_next_pat;
          r_frame_cnt <= '0;
        end else begin
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end
      end

      case (r_state)
        ST_MANUAL: begin
          if (w_auto_rise) begin
            r_state       <= ST_AUTO;
            r_auto_active <= 1'b1;
            r_frame_cnt   <= '0;
          end
        end
        ST_AUTO: begin
          if (w_auto_fall) begin
            r_state       <= ST_MANUAL;
            r_auto_active <= 1'b0;
          end
        end
        default: begin
          r_state       <= ST_MANUAL;
          r_auto_active <= 1'b0;
        end
      endcase
    end
  end

  assign o_pattern     = r_pattern;
  assign o_frame_start = r_frame_start;
  assign o_auto_active = r_auto_active;

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Bench for vga_pattern_sequencer: two instances (4 and 3 patterns) share one
// stimulus stream and are compared every cycle against a behavioural model.
module tb_vga_pattern_sequencer;

  localparam int DB  = 4;
  localparam int FPP = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sel0 = 1'b0;
  logic       sel1 = 1'b0;
  logic       auto_sw = 1'b0;
  logic       vsync = 1'b1;
  logic [2:0] pat4, pat3;
  logic       fs4, fs3, aa4, aa3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vga_pattern_sequencer #(
    .NUM_PATTERNS(4), .PATTERN_WIDTH(3), .DEBOUNCE_CYCLES(DB), .FRAMES_PER_PATTERN(FPP)
  ) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_sel0(sel0), .i_sel1(sel1), .i_auto(auto_sw),
    .i_vsync(vsync), .o_pattern(pat4), .o_frame_start(fs4), .o_auto_active(aa4)
  );

  vga_pattern_sequencer #(
    .NUM_PATTERNS(3), .PATTERN_WIDTH(3), .DEBOUNCE_CYCLES(DB), .FRAMES_PER_PATTERN(FPP)
  ) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_sel0(sel0), .i_sel1(sel1), .i_auto(auto_sw),
    .i_vsync(vsync), .o_pattern(pat3), .o_frame_start(fs3), .o_auto_active(aa3)
  );

  // vsync: 40-cycle period, high for phases 0..29, driven away from posedge.
  int phase = 0;
  always @(negedge clk) begin
    phase = (phase + 1) % 40;
    vsync = (phase < 30);
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model.
  int          m_np [2] = '{4, 3};
  int          m_pat[2];
  int          m_fcnt;
  bit          m_auto, m_autoprev, m_fs, m_vsprev;
  bit          m_st  [3];
  logic [15:0] m_hist[3];

  function automatic int target(input int np, input bit s0, input bit s1);
    int t;
    t = s0 * 2 + s1;
    return (t >= np) ? np - 1 : t;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pat = '{0, 0};
      m_fcnt = 0; m_auto = 0; m_autoprev = 0; m_fs = 0; m_vsprev = 1;
      for (int j = 0; j < 3; j++) begin
        m_st[j] = 0;
        m_hist[j] = '0;
      end
    end else begin
      bit fs_now;
      bit raw[3];
      bit all_diff;
      raw = '{sel0, sel1, auto_sw};
      fs_now = vsync && !m_vsprev;
      if (fs_now) begin
        if (!m_auto) begin
          for (int k = 0; k < 2; k++) m_pat[k] = target(m_np[k], m_st[0], m_st[1]);
        end else if (m_fcnt == FPP - 1) begin
          for (int k = 0; k < 2; k++) m_pat[k] = (m_pat[k] + 1) % m_np[k];
          m_fcnt = 0;
        end else begin
          m_fcnt++;
        end
      end
      if (m_st[2] && !m_autoprev && !m_auto) begin
        m_auto = 1;
        m_fcnt = 0;
      end else if (!m_st[2] && m_autoprev && m_auto) begin
        m_auto = 0;
      end
      m_autoprev = m_st[2];
      m_fs = fs_now;
      m_vsprev = vsync;
      // Stable flips once the input, two cycles late, has held the other value DB cycles.
      for (int j = 0; j < 3; j++) begin
        m_hist[j] = {m_hist[j][14:0], raw[j]};
        all_diff = 1;
        for (int i = 2; i < DB + 2; i++) if (m_hist[j][i] == m_st[j]) all_diff = 0;
        if (all_diff) m_st[j] = !m_st[j];
      end
    end
  end

  always @(negedge clk) begin
    chk("model_pat4", int'(pat4), m_pat[0]);
    chk("model_pat3", int'(pat3), m_pat[1]);
    chk("model_fs4", int'(fs4), int'(m_fs));
    chk("model_fs3", int'(fs3), int'(m_fs));
    chk("model_auto4", int'(aa4), int'(m_auto));
    chk("model_auto3", int'(aa3), int'(m_auto));
  end

  task automatic wait_fs();
    int n;
    n = 0;
    @(negedge clk);
    while (!fs4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("frame_start_seen", int'(fs4), 1);
  endtask

  initial begin
    repeat (10) @(negedge clk);
    rst_n = 1'b1;

    // Reset released with vsync high: no false frame start.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("rst_vs_high_fs", int'(fs4), 0);
      chk("rst_vs_high_pat", int'(pat4), 0);
      chk("rst_vs_high_auto", int'(aa4), 0);
    end

    // Manual select 10 -> pattern 2, committed only at the next frame start.
    sel0 = 1'b1;
    repeat (10) @(negedge clk);
    chk("manual_hold_pat", int'(pat4), 0);
    wait_fs();
    chk("manual_commit_pat4", int'(pat4), 2);
    chk("manual_commit_pat3", int'(pat3), 2);

    // Three-cycle glitch on sel1 must be rejected.
    sel1 = 1'b1;
    repeat (3) @(negedge clk);
    sel1 = 1'b0;
    wait_fs();
    wait_fs();
    chk("bounce_pat4", int'(pat4), 2);
    chk("bounce_pat3", int'(pat3), 2);

    // Auto cycling from pattern 2.
    auto_sw = 1'b1;
    repeat (10) @(negedge clk);
    chk("auto_active", int'(aa4), 1);
    chk("auto_entry_pat", int'(pat4), 2);
    repeat (3) wait_fs();
    chk("auto_3rd_pat4", int'(pat4), 3);
    chk("auto_3rd_pat3", int'(pat3), 0);
    repeat (3) wait_fs();
    chk("auto_6th_wrap_pat4", int'(pat4), 0);
    chk("auto_6th_pat3", int'(pat3), 1);

    // Back to manual with select 11: clamp on the 3-pattern instance.
    auto_sw = 1'b0;
    sel0 = 1'b1;
    sel1 = 1'b1;
    repeat (10) @(negedge clk);
    chk("auto_exit", int'(aa4), 0);
    wait_fs();
    chk("clamp_pat3", int'(pat3), 2);
    chk("no_clamp_pat4", int'(pat4), 3);

    // Enter auto at pattern 3, then reset mid-frame.
    auto_sw = 1'b1;
    wait_fs();
    chk("pre_reset_auto", int'(aa4), 1);
    chk("pre_reset_pat", int'(pat4), 3);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pat4", int'(pat4), 0);
    chk("async_rst_pat3", int'(pat3), 0);
    chk("async_rst_auto", int'(aa4), 0);
    chk("async_rst_fs", int'(fs4), 0);
    auto_sw = 1'b0;
    sel0 = 1'b0;
    sel1 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_manual", int'(aa4), 0);
    wait_fs();
    chk("post_rst_pat", int'(pat4), 0);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
